// File: rtl/neuron_input_streamer_pkg.sv
// Shared types and helpers for the neuron input streamer and the neuron processor.
// Holds the beat-count helper, the streamer FSM state type and the threshold width default.
package neuron_input_streamer_pkg;

    localparam int THRESH_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } streamer_state_t;

    function automatic int beats_f(input int num_inputs, input int parallel_inputs);
        return (num_inputs + parallel_inputs - 1) / parallel_inputs;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_beat_counter.sv
// Nested beat/neuron counter with a flat weight address that tracks neuron*BEATS+beat.
// Advances once per issued weight read and wraps to zero after the final beat of the final neuron.
module neuron_beat_counter #(
    parameter int BEATS       = 2,
    parameter int NUM_NEURONS = 4,
    parameter int BEAT_W      = 1,
    parameter int NEURON_W    = 2,
    parameter int ADDR_W      = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                advance,
    output logic [BEAT_W-1:0]   beat,
    output logic [NEURON_W-1:0] neuron,
    output logic [ADDR_W-1:0]   addr,
    output logic                first_beat,
    output logic                last_beat,
    output logic                last_neuron
);

    logic [BEAT_W-1:0]   beat_reg;
    logic [NEURON_W-1:0] neuron_reg;
    logic [ADDR_W-1:0]   addr_reg;

    assign first_beat  = (beat_reg == '0);
    assign last_beat   = (beat_reg == BEAT_W'(BEATS - 1));
    assign last_neuron = (neuron_reg == NEURON_W'(NUM_NEURONS - 1));

    assign beat   = beat_reg;
    assign neuron = neuron_reg;
    assign addr   = addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_reg   <= '0;
            neuron_reg <= '0;
            addr_reg   <= '0;
        end else if (clear) begin
            beat_reg   <= '0;
            neuron_reg <= '0;
            addr_reg   <= '0;
        end else if (advance) begin
            if (last_beat) begin
                beat_reg <= '0;
                if (last_neuron) begin
                    neuron_reg <= '0;
                    addr_reg   <= '0;
                end else begin
                    neuron_reg <= neuron_reg + NEURON_W'(1);
                    addr_reg   <= addr_reg + ADDR_W'(1);
                end
            end else begin
                beat_reg <= beat_reg + BEAT_W'(1);
                addr_reg <= addr_reg + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/neuron_input_streamer.sv
// Captures one activation vector and replays it once per neuron alongside that neuron's weights.
// Define NEURON_STREAMER_GAP_EN to insert one idle cycle after every eof beat.
module neuron_input_streamer
    import neuron_input_streamer_pkg::*;
#(
    parameter int PARALLEL_INPUTS = 1,
    parameter int NUM_INPUTS      = 2,
    parameter int NUM_NEURONS     = 4,
    parameter int THRESH_W        = THRESH_W_DEFAULT,
    localparam int BEATS          = beats_f(NUM_INPUTS, PARALLEL_INPUTS),
    localparam int BEAT_W         = idx_width_f(BEATS),
    localparam int NEURON_W       = idx_width_f(NUM_NEURONS),
    localparam int ADDR_W         = idx_width_f(NUM_NEURONS * BEATS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [NUM_INPUTS-1:0]      x_vec,
    output logic                       w_rd_en,
    output logic [ADDR_W-1:0]          w_rd_addr,
    input  logic [PARALLEL_INPUTS-1:0] w_rd_data,
    output logic                       th_rd_en,
    output logic [NEURON_W-1:0]        th_rd_addr,
    input  logic [THRESH_W-1:0]        th_rd_data,
    output logic [PARALLEL_INPUTS-1:0] x,
    output logic [PARALLEL_INPUTS-1:0] w,
    output logic [THRESH_W-1:0]        threshold,
    output logic                       valid_in,
    output logic                       eof,
    output logic                       busy,
    output logic                       done
);

`ifdef NEURON_STREAMER_GAP_EN
    localparam logic       GAP_EN     = 1'b1;
    localparam logic [1:0] DRAIN_LAST = 2'd2;
`else
    localparam logic       GAP_EN     = 1'b0;
    localparam logic [1:0] DRAIN_LAST = 2'd1;
`endif

    localparam int XPAD_W = BEATS * PARALLEL_INPUTS;

    streamer_state_t state_reg, state_next;
    logic            gap_reg, gap_next;
    logic [1:0]      drain_cnt_reg, drain_cnt_next;
    logic            done_reg, done_next;
    logic            start_ready_reg;
    logic [NUM_INPUTS-1:0] x_vec_reg;

    logic rd_issue;
    logic capture;
    logic cnt_clear;

    logic [BEAT_W-1:0]   cnt_beat;
    logic [NEURON_W-1:0] cnt_neuron;
    logic [ADDR_W-1:0]   cnt_addr;
    logic                cnt_first, cnt_last_beat, cnt_last_neuron;

    // Stage 1: read in flight, memory data is valid while these are set.
    logic              valid1_reg, first1_reg, last1_reg;
    logic [BEAT_W-1:0] beat1_reg;

    // Stage 2: registered outputs.
    logic [PARALLEL_INPUTS-1:0] x_reg, w_reg;
    logic [THRESH_W-1:0]        thr_reg;
    logic                       valid_reg, eof_reg;

    logic [XPAD_W-1:0]          x_pad;
    logic [PARALLEL_INPUTS-1:0] pad_mask;
    logic [PARALLEL_INPUTS-1:0] x_sel;
    logic [PARALLEL_INPUTS-1:0] w_beat;

    neuron_beat_counter #(
        .BEATS       (BEATS),
        .NUM_NEURONS (NUM_NEURONS),
        .BEAT_W      (BEAT_W),
        .NEURON_W    (NEURON_W),
        .ADDR_W      (ADDR_W)
    ) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (cnt_clear),
        .advance     (rd_issue),
        .beat        (cnt_beat),
        .neuron      (cnt_neuron),
        .addr        (cnt_addr),
        .first_beat  (cnt_first),
        .last_beat   (cnt_last_beat),
        .last_neuron (cnt_last_neuron)
    );

    always_comb begin
        state_next     = state_reg;
        gap_next       = 1'b0;
        drain_cnt_next = '0;
        done_next      = 1'b0;
        rd_issue       = 1'b0;
        capture        = 1'b0;
        cnt_clear      = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_clear = 1'b1;
                if (start_valid && start_ready_reg) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                rd_issue = !gap_reg;
                if (rd_issue && cnt_last_beat) begin
                    if (cnt_last_neuron) begin
                        state_next = DRAIN;
                    end else begin
                        gap_next = GAP_EN;
                    end
                end
            end
            DRAIN: begin
                // Wait for the final beat (and its trailing gap, if enabled) to leave the pipeline.
                if (drain_cnt_reg == DRAIN_LAST) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            gap_reg         <= 1'b0;
            drain_cnt_reg   <= '0;
            done_reg        <= 1'b0;
            start_ready_reg <= 1'b0;
            x_vec_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            gap_reg         <= gap_next;
            drain_cnt_reg   <= drain_cnt_next;
            done_reg        <= done_next;
            start_ready_reg <= (state_next == IDLE);
            if (capture) begin
                x_vec_reg <= x_vec;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < XPAD_W; gi++) begin : g_xpad
            if (gi < NUM_INPUTS) begin : g_act
                assign x_pad[gi] = x_vec_reg[gi];
            end else begin : g_zero
                assign x_pad[gi] = 1'b0;
            end
        end
        for (gi = 0; gi < PARALLEL_INPUTS; gi++) begin : g_mask
            // Padded lanes carry w=1 against x=0 so their XNOR adds nothing to the popcount.
            assign pad_mask[gi] = (((BEATS - 1) * PARALLEL_INPUTS + gi) >= NUM_INPUTS);
        end
    endgenerate

    always_comb begin
        x_sel = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat1_reg == BEAT_W'(b)) begin
                x_sel = x_pad[b*PARALLEL_INPUTS +: PARALLEL_INPUTS];
            end
        end
    end

    assign w_beat = w_rd_data | (last1_reg ? pad_mask : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_reg <= 1'b0;
            first1_reg <= 1'b0;
            last1_reg  <= 1'b0;
            beat1_reg  <= '0;
            valid_reg  <= 1'b0;
            eof_reg    <= 1'b0;
            x_reg      <= '0;
            w_reg      <= '0;
            thr_reg    <= '0;
        end else begin
            valid1_reg <= rd_issue;
            first1_reg <= cnt_first;
            last1_reg  <= cnt_last_beat;
            beat1_reg  <= cnt_beat;
            valid_reg  <= valid1_reg;
            eof_reg    <= valid1_reg && last1_reg;
            if (valid1_reg) begin
                x_reg <= x_sel;
                w_reg <= w_beat;
            end
            if (valid1_reg && first1_reg) begin
                thr_reg <= th_rd_data;
            end
        end
    end

    assign start_ready = start_ready_reg;
    assign w_rd_en     = rd_issue;
    assign w_rd_addr   = cnt_addr;
    assign th_rd_en    = rd_issue && cnt_first;
    assign th_rd_addr  = cnt_neuron;
    assign x           = x_reg;
    assign w           = w_reg;
    assign threshold   = thr_reg;
    assign valid_in    = valid_reg;
    assign eof         = eof_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;

endmodule
